// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit_pkg
// Description : Shared EX-stage definitions for the iterative multiply/divide
//               unit: datapath width, operation encodings, FSM state
//               encodings and an absolute-value helper.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package ex_muldiv_unit_pkg;

    localparam int XLEN = 32;

    // Operation encodings as decoded in ID and carried in EX_MulDivOp.
    typedef enum logic [1:0] {
        MULDIV_MULT  = 2'b00,
        MULDIV_MULTU = 2'b01,
        MULDIV_DIV   = 2'b10,
        MULDIV_DIVU  = 2'b11
    } muldiv_op_t;

    // Unit FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // Two's-complement magnitude for signed operands; unsigned operands pass
    // through untouched. 0x80000000 maps to itself, which reads correctly as
    // an unsigned magnitude of 2^31.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                                 input logic            is_signed);
        abs_val = (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage : ex_muldiv_unit_pkg
`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit_if
// Description : EX-stage bus between the pipeline and the multiply/divide
//               unit. master = pipeline side (drives operands/control),
//               slave = the unit (drives busy and HI/LO read data).
// Ports       : EX_MulDivStart, EX_MulDivOp[1:0], EX_Flush, EX_DataBusA/B,
//               EX_HiLoWrite[1:0], EX_HiLoSel  (master -> slave)
//               MulDiv_Busy, EX_HiLoOut, HI, LO (slave -> master)
// Revision    : 1.0  initial release
// ============================================================================
interface ex_muldiv_unit_if;
    import ex_muldiv_unit_pkg::*;

    logic            EX_MulDivStart;
    logic [1:0]      EX_MulDivOp;
    logic            EX_Flush;
    logic [XLEN-1:0] EX_DataBusA;
    logic [XLEN-1:0] EX_DataBusB;
    logic [1:0]      EX_HiLoWrite;
    logic            EX_HiLoSel;
    logic            MulDiv_Busy;
    logic [XLEN-1:0] EX_HiLoOut;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;

    modport master (
        output EX_MulDivStart, EX_MulDivOp, EX_Flush, EX_DataBusA, EX_DataBusB,
               EX_HiLoWrite, EX_HiLoSel,
        input  MulDiv_Busy, EX_HiLoOut, HI, LO
    );

    modport slave (
        input  EX_MulDivStart, EX_MulDivOp, EX_Flush, EX_DataBusA, EX_DataBusB,
               EX_HiLoWrite, EX_HiLoSel,
        output MulDiv_Busy, EX_HiLoOut, HI, LO
    );

endinterface : ex_muldiv_unit_if
`default_nettype wire

// File: rtl/ex_muldiv_unit_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of the multiply/divide datapath.
//               Multiply: shift-add on a 64-bit accumulator whose low half
//               holds the remaining multiplier bits.
//               Divide: restoring step; accumulator is {remainder, dividend}
//               shifted left one bit per iteration.
// Ports       : is_div   in   1     0 = multiply step, 1 = divide step
//               acc      in   64    accumulator / partial remainder
//               operand  in   32    multiplicand or divisor magnitude
//               acc_next out  64    accumulator after this step (LSB 0 for
//                                   divide; the quotient bit is separate)
//               q_bit    out  1     quotient bit produced (0 for multiply)
// Revision    : 1.0  initial release
// ============================================================================
module muldiv_step
    import ex_muldiv_unit_pkg::*;
(
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next,
    output logic              q_bit
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   partial;
    logic [XLEN:0]   divisor_ext;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] new_rem;

    always_comb begin
        // Multiply: add the multiplicand to the upper half when the current
        // multiplier bit is set; the carry becomes the new top bit after the
        // right shift.
        mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand : {XLEN{1'b0}})};

        // Divide: 33-bit partial remainder = {remainder, next dividend bit}.
        // Since remainder < divisor, the subtraction result always fits in
        // 32 bits whenever it is kept.
        partial     = acc[2*XLEN-1:XLEN-1];
        divisor_ext = {1'b0, operand};
        diff        = partial - divisor_ext;
        q_bit       = 1'b0;
        new_rem     = partial[XLEN-1:0];

        if (is_div) begin
            if (partial >= divisor_ext) begin
                q_bit   = 1'b1;
                new_rem = diff[XLEN-1:0];
            end
            acc_next = {new_rem, acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative 32x32 multiply / 32/32 divide unit with the
//               architectural HI/LO registers. Operands are reduced to
//               magnitudes on start, iterated 32 times, and the signs are
//               restored in a final FIX cycle that writes HI/LO.
// Ports       : sysclk  in  clock, rising edge
//               reset   in  synchronous active-low reset
//               bus     slave side of ex_muldiv_unit_if (operands, control,
//                       busy flag, HI/LO read data)
// Revision    : 1.0  initial release
// ============================================================================
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
(
    input  logic              sysclk,
    input  logic              reset,
    ex_muldiv_unit_if.slave   bus
);

    muldiv_state_t     state, state_next;
    logic [4:0]        cnt, cnt_next;
    logic [2*XLEN-1:0] acc, acc_next;
    logic [XLEN-1:0]   operand, operand_next;
    logic              op_div, op_div_next;
    logic              neg_lo, neg_lo_next;   // product / quotient sign
    logic              neg_hi, neg_hi_next;   // remainder sign
    logic              div0, div0_next;
    logic [XLEN-1:0]   hi, hi_next;
    logic [XLEN-1:0]   lo, lo_next;
    logic              busy;

    logic [2*XLEN-1:0] step_acc;
    logic              step_q;

    logic              start_ok;
    logic              is_signed;
    logic              is_div;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [2*XLEN-1:0] product;

    muldiv_step u_step (
        .is_div   (op_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            acc     <= '0;
            operand <= '0;
            op_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            acc     <= acc_next;
            operand <= operand_next;
            op_div  <= op_div_next;
            neg_lo  <= neg_lo_next;
            neg_hi  <= neg_hi_next;
            div0    <= div0_next;
            hi      <= hi_next;
            lo      <= lo_next;
            busy    <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        acc_next     = acc;
        operand_next = operand;
        op_div_next  = op_div;
        neg_lo_next  = neg_lo;
        neg_hi_next  = neg_hi;
        div0_next    = div0;
        hi_next      = hi;
        lo_next      = lo;

        start_ok  = bus.EX_MulDivStart && !bus.EX_Flush;
        is_signed = !bus.EX_MulDivOp[0];
        is_div    = bus.EX_MulDivOp[1];
        sign_a    = is_signed && bus.EX_DataBusA[XLEN-1];
        sign_b    = is_signed && bus.EX_DataBusB[XLEN-1];
        abs_a     = abs_val(bus.EX_DataBusA, is_signed);
        abs_b     = abs_val(bus.EX_DataBusB, is_signed);
        product   = neg_lo ? (~acc + 1'b1) : acc;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    op_div_next = is_div;
                    neg_lo_next = sign_a ^ sign_b;
                    neg_hi_next = sign_a;
                    cnt_next    = 5'd31;
                    if (is_div && (bus.EX_DataBusB == '0)) begin
                        // Keep the raw dividend so FIX can return it in HI.
                        div0_next    = 1'b1;
                        acc_next     = {{XLEN{1'b0}}, bus.EX_DataBusA};
                        operand_next = '0;
                        state_next   = FIX;
                    end else begin
                        // Divide shifts the dividend out of the low half;
                        // multiply consumes the multiplier from the low half.
                        div0_next    = 1'b0;
                        acc_next     = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
                        operand_next = is_div ? abs_b : abs_a;
                        state_next   = CALC;
                    end
                end else if (!bus.EX_Flush) begin
                    if (bus.EX_HiLoWrite[1]) hi_next = bus.EX_DataBusA;
                    if (bus.EX_HiLoWrite[0]) lo_next = bus.EX_DataBusA;
                end
            end

            CALC: begin
                // Quotient bit drops into the LSB vacated by the left shift.
                acc_next = step_acc | {{(2*XLEN-1){1'b0}}, step_q};
                if (cnt == 5'd0) begin
                    state_next = FIX;
                end else begin
                    cnt_next = cnt - 5'd1;
                end
            end

            FIX: begin
                if (div0) begin
                    lo_next = {XLEN{1'b1}};
                    hi_next = acc[XLEN-1:0];
                end else if (op_div) begin
                    lo_next = neg_lo ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
                    hi_next = neg_hi ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
                end else begin
                    lo_next = product[XLEN-1:0];
                    hi_next = product[2*XLEN-1:XLEN];
                end
                div0_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.MulDiv_Busy = busy;
    assign bus.HI          = hi;
    assign bus.LO          = lo;
    assign bus.EX_HiLoOut  = bus.EX_HiLoSel ? hi : lo;

endmodule : ex_muldiv_unit
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Self-checking bench for ex_muldiv_unit: directed cases plus
//               randomized operations compared against an arithmetic model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic sysclk = 1'b0;
    logic reset;

    ex_muldiv_unit_if bus();

    ex_muldiv_unit dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {HI, LO} straight from the arithmetic definition.
    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin p = sa * sb; return p; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sb; r = sa % sb;
                qv = q; rv = r;
                return {rv[31:0], qv[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, {32'd0, bus.HI}, {32'd0, m_hi});
        check({tag, "_lo"}, {32'd0, bus.LO}, {32'd0, m_lo});
        bus.EX_HiLoSel = 1'b0; #1;
        check({tag, "_rdlo"}, {32'd0, bus.EX_HiLoOut}, {32'd0, m_lo});
        bus.EX_HiLoSel = 1'b1; #1;
        check({tag, "_rdhi"}, {32'd0, bus.EX_HiLoOut}, {32'd0, m_hi});
        bus.EX_HiLoSel = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] wr);
        int          n;
        logic [63:0] r;
        @(negedge sysclk);
        bus.EX_MulDivStart = 1'b1;
        bus.EX_MulDivOp    = op;
        bus.EX_DataBusA    = a;
        bus.EX_DataBusB    = b;
        bus.EX_HiLoWrite   = wr;
        @(posedge sysclk); #1;
        bus.EX_MulDivStart = 1'b0;
        bus.EX_HiLoWrite   = 2'b00;
        bus.EX_DataBusA    = $urandom;
        bus.EX_DataBusB    = $urandom;
        check({tag, "_busy_set"}, {63'd0, bus.MulDiv_Busy}, 64'd1);
        n = 0;
        while (bus.MulDiv_Busy && n < 200) begin
            @(posedge sysclk); #1;
            n++;
            if (n == 5) check({tag, "_rd_while_busy"}, {32'd0, bus.EX_HiLoOut}, {32'd0, m_lo});
        end
        check({tag, "_busy_len"}, 64'(n), ((op[1] && b == 32'd0) ? 64'd1 : 64'd33));
        r    = ref_op(op, a, b);
        m_hi = r[63:32];
        m_lo = r[31:0];
        check_regs(tag);
    endtask

    task automatic move(input string tag, input logic [1:0] wr, input logic [31:0] a,
                        input logic flush);
        @(negedge sysclk);
        bus.EX_HiLoWrite = wr;
        bus.EX_DataBusA  = a;
        bus.EX_Flush     = flush;
        @(posedge sysclk); #1;
        bus.EX_HiLoWrite = 2'b00;
        bus.EX_Flush     = 1'b0;
        if (!flush) begin
            if (wr[1]) m_hi = a;
            if (wr[0]) m_lo = a;
        end
        check({tag, "_busy"}, {63'd0, bus.MulDiv_Busy}, 64'd0);
        check_regs(tag);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;

        reset              = 1'b0;
        bus.EX_MulDivStart = 1'b0;
        bus.EX_MulDivOp    = 2'b00;
        bus.EX_Flush       = 1'b0;
        bus.EX_DataBusA    = 32'd0;
        bus.EX_DataBusB    = 32'd0;
        bus.EX_HiLoWrite   = 2'b00;
        bus.EX_HiLoSel     = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        check("rst_busy", {63'd0, bus.MulDiv_Busy}, 64'd0);
        check_regs("rst");
        @(negedge sysclk);
        reset = 1'b1;

        run_op("mult", 2'b00, 32'hFFFFFFFE, 32'd3, 2'b00);
        check("mult_spec", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFFA);
        run_op("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00);
        check("multu_spec", {bus.HI, bus.LO}, 64'hFFFFFFFE_00000001);
        run_op("div", 2'b10, 32'hFFFFFFF9, 32'd2, 2'b00);
        check("div_spec", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFFD);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 2'b00);
        check("div_ovf_spec", {bus.HI, bus.LO}, 64'h00000000_80000000);
        run_op("divu0", 2'b11, 32'h64, 32'd0, 2'b00);
        check("divu0_spec", {bus.HI, bus.LO}, 64'h00000064_FFFFFFFF);
        run_op("div0_signed", 2'b10, 32'hFFFFFF00, 32'd0, 2'b00);

        move("mthi", 2'b10, 32'h12345678, 1'b0);
        move("mtlo", 2'b01, 32'hCAFEF00D, 1'b0);
        move("mtboth", 2'b11, 32'h0BADBEEF, 1'b0);
        move("mt_flushed", 2'b11, 32'h55555555, 1'b1);

        // Start while flushed: must not begin an operation.
        @(negedge sysclk);
        bus.EX_MulDivStart = 1'b1;
        bus.EX_Flush       = 1'b1;
        bus.EX_MulDivOp    = 2'b01;
        bus.EX_DataBusA    = 32'd9;
        bus.EX_DataBusB    = 32'd9;
        @(posedge sysclk); #1;
        bus.EX_MulDivStart = 1'b0;
        bus.EX_Flush       = 1'b0;
        check("flush_busy", {63'd0, bus.MulDiv_Busy}, 64'd0);
        @(posedge sysclk); #1;
        check("flush_busy2", {63'd0, bus.MulDiv_Busy}, 64'd0);
        check_regs("flush");

        // Start and move together: the move is dropped.
        run_op("start_mt", 2'b01, 32'd2, 32'd3, 2'b11);

        // Reset in the middle of a multiply.
        @(negedge sysclk);
        bus.EX_MulDivStart = 1'b1;
        bus.EX_MulDivOp    = 2'b00;
        bus.EX_DataBusA    = 32'h00012345;
        bus.EX_DataBusB    = 32'hFFFF0001;
        @(posedge sysclk); #1;
        bus.EX_MulDivStart = 1'b0;
        repeat (9) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;
        @(posedge sysclk); #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("midrst_busy", {63'd0, bus.MulDiv_Busy}, 64'd0);
        check_regs("midrst");
        @(negedge sysclk);
        reset = 1'b1;
        run_op("after_rst", 2'b01, 32'd5, 32'd7, 2'b00);
        check("after_rst_spec", {bus.HI, bus.LO}, 64'd35);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = 32'd0 - 32'($urandom_range(1, 15));
                2:       b = 32'd0;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
            run_op("rand", op, a, b, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0) move("rand_mt", 2'($urandom_range(1, 3)), $urandom, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ex_muldiv_unit
`default_nettype wire

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the ALU. It consumes the operand buses and decoded control leaving the ID/EX pipeline register and hands HI/LO read data to the EX/MEM register through the EX result mux. It executes MULT/MULTU/DIV/DIVU over many cycles and raises a busy flag. The hazard unit uses that flag to stall any later HI/LO-touching instruction in ID.

## Interface
- XLEN, 32: operand and HI/LO width. Only 32 is supported.
- sysclk  in  1  clock, all state updates on rising edge
- reset  in  1  reset; synchronous, active-low
- EX_MulDivStart  in  1  a valid MULT/MULTU/DIV/DIVU is in EX this cycle
- EX_MulDivOp  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- EX_Flush  in  1  the EX instruction is squashed; suppresses Start and HiLoWrite
- EX_DataBusA  in  32  rs operand, already forwarded (multiplicand/dividend)
- EX_DataBusB  in  32  rt operand, already forwarded (multiplier/divisor)
- EX_HiLoWrite  in  2  bit1 MTHI, bit0 MTLO; write EX_DataBusA
- EX_HiLoSel  in  1  0 selects LO, 1 selects HI on EX_HiLoOut (MFLO/MFHI)
- MulDiv_Busy  out  1  registered; operation in flight
- EX_HiLoOut  out  32  combinational read of selected HI/LO
- HI, LO  out  32 each  architectural registers (debug/trace)

## Operation
- States: IDLE, CALC, FIX.
- IDLE, Start=1, Flush=0:
  - Latch |A| and |B|. Signed ops use two's-complement absolute value; unsigned ops pass operands through.
  - Latch result-sign flags:
    - product sign = signA^signB
    - quotient sign = signA^signB
    - remainder sign = signA
  - Load iteration counter with 31.
  - Go to CALC.
- Divide by zero (DIV/DIVU with B==0): skip CALC, go directly to FIX with the zero flag set.
- CALC, multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- CALC, divide: restoring divide, one quotient bit per cycle, 33-bit partial remainder.
- CALC exit: counter decrements each cycle; leave to FIX after the iteration with counter==0, giving 32 iterations.
- FIX, writes HI/LO then returns to IDLE:
  - Multiply: {HI,LO} = product, negated if the sign flag is set.
  - Divide: LO = quotient, HI = remainder, each negated per its flag.
  - Divide by zero: LO=32'hFFFFFFFF, HI=original dividend; no negation.
- Signed overflow 0x80000000 / -1 falls out of the abs path: LO=0x80000000, HI=0. No special case.
- MTHI/MTLO: in IDLE with Flush=0, HiLoWrite bits write EX_DataBusA to HI and/or LO. Both bits may be set.
- Start and HiLoWrite in the same cycle: Start wins and the write is dropped.
- Start or HiLoWrite while not IDLE: ignored. The hazard unit guarantees this never occurs.
- EX_HiLoOut is always the current register value. A read while Busy returns the pre-operation value.
- EX_Flush has no effect on an operation already in CALC/FIX.

## Timing
- Reset (reset=0 at an edge): state IDLE, counter 0, HI=0, LO=0, MulDiv_Busy=0, internal accumulators 0. EX_HiLoOut=0 follows.
- Start sampled at edge N:
  - Busy=1 after edge N.
  - CALC iterations at edges N+1..N+32; FIX after N+32.
  - HI/LO written and Busy=0 after edge N+33.
  - Busy is high for 33 cycles.
- Divide by zero: Busy high for exactly 1 cycle; HI/LO valid after N+1.
- A new Start is accepted on the first cycle Busy=0.
- Reset mid-operation aborts immediately. HI/LO return to 0, not the previous value.
- MTHI/MTLO: written at the sampling edge; visible on EX_HiLoOut the following cycle.

## Structure
- Shared pipeline package:
  - MULDIV_MULT/MULTU/DIV/DIVU op encodings
  - state encodings IDLE/CALC/FIX
  - XLEN
- One sub-module, muldiv_step: combinational single iteration.
  - Inputs: op, accumulator/partial remainder, operand.
  - Outputs: next accumulator and quotient bit.
- ex_muldiv_unit keeps the FSM, counter, sign flags and HI/LO.

## Test plan
- Signed multiply: MULT A=0xFFFFFFFE, B=3 -> Busy 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned multiply: MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; EX_HiLoSel=0/1 reads LO/HI.
- Signed divide and overflow:
  - DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: DIVU A=0x64, B=0 -> Busy exactly 1 cycle, HI=0x64, LO=0xFFFFFFFF.
- Move and qualifier checks:
  - MTHI with A=0x12345678 -> HI=0x12345678, LO unchanged.
  - Start with EX_Flush=1 -> Busy stays 0, HI/LO unchanged.
  - Start+HiLoWrite together -> only the operation occurs.
- Reset mid-operation: reset=0 at cycle 10 of a MULT -> next cycle Busy=0, HI=LO=0. A MULTU 5*7 started afterwards gives LO=35, HI=0.
